// File: rtl/hex_display_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hex_display_pkg
//  Desc     : Shared types and default period constants for the HEX0
//             blinking-counter datapath and its control stages.
//  Revision : 1.0 - initial release
// ============================================================================
package hex_display_pkg;

    // Speed index: 0 = fastest, SPEED_MAX = slowest
    typedef logic [1:0] speed_t;

    localparam speed_t SPEED_MAX = 2'd3;

    // Default divider periods at a 50 MHz system clock
    localparam logic [31:0] PERIOD_FULL       = 32'd1;
    localparam logic [31:0] PERIOD_1HZ        = 32'd50_000_000;
    localparam logic [31:0] PERIOD_HALF_HZ    = 32'd100_000_000;
    localparam logic [31:0] PERIOD_QUARTER_HZ = 32'd200_000_000;

endpackage
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : key_debounce
//  Desc     : Synchronises an active-low raw push-button, debounces it with a
//             consecutive-cycle counter and emits a one-cycle press pulse on
//             each accepted high-to-low transition.
//  Revision : 1.0 - initial release
// ============================================================================
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clock,
    input  logic reset,
    input  logic key_n,
    output logic stable,
    output logic press
);

    localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             stable_prev;
    logic [CNT_W-1:0] cnt;

    // Two-flop synchroniser; idle level of the button is high
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
        end
    end

    // Accept a new level only after it persists for DEBOUNCE_CYCLES cycles;
    // any return to the stable level restarts the count
    always_ff @(posedge clock) begin
        if (reset) begin
            stable      <= 1'b1;
            stable_prev <= 1'b1;
            cnt         <= '0;
        end else begin
            stable_prev <= stable;
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                stable <= sync2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Falling edge of the debounced level is a press; releases are ignored
    always_comb begin
        press = stable_prev & ~stable;
    end

endmodule
`default_nettype wire

// File: rtl/speed_select.sv
`default_nettype none
// ============================================================================
//  Module   : speed_select
//  Desc     : Steps a 2-bit speed index from debounced faster/slower buttons
//             and presents the matching registered divider period with a
//             one-cycle changed strobe.
//  Revision : 1.0 - initial release
// ============================================================================
module speed_select
    import hex_display_pkg::*;
#(
    parameter int          DEBOUNCE_CYCLES = 1000000,
    parameter logic [31:0] PERIOD_0        = PERIOD_FULL,
    parameter logic [31:0] PERIOD_1        = PERIOD_1HZ,
    parameter logic [31:0] PERIOD_2        = PERIOD_HALF_HZ,
    parameter logic [31:0] PERIOD_3        = PERIOD_QUARTER_HZ,
    parameter int          INIT_SPEED      = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        key_up_n,
    input  logic        key_down_n,
    output speed_t      speed,
    output logic [31:0] period,
    output logic        changed
);

    logic   up_press;
    logic   down_press;
    speed_t speed_next;
    logic   changed_next;

    function automatic logic [31:0] period_of(input speed_t s);
        case (s)
            2'd0:    period_of = PERIOD_0;
            2'd1:    period_of = PERIOD_1;
            2'd2:    period_of = PERIOD_2;
            default: period_of = PERIOD_3;
        endcase
    endfunction

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_up (
        .clock  (clock),
        .reset  (reset),
        .key_n  (key_up_n),
        .stable (),
        .press  (up_press)
    );

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_down (
        .clock  (clock),
        .reset  (reset),
        .key_n  (key_down_n),
        .stable (),
        .press  (down_press)
    );

    // Next speed: single press steps with saturation, simultaneous presses cancel
    always_comb begin
        speed_next   = speed;
        changed_next = 1'b0;
        if (up_press && !down_press && (speed != 2'd0)) begin
            speed_next   = speed - 2'd1;
            changed_next = 1'b1;
        end else if (down_press && !up_press && (speed != SPEED_MAX)) begin
            speed_next   = speed + 2'd1;
            changed_next = 1'b1;
        end
    end

    // Period follows the next speed so all three outputs change together
    always_ff @(posedge clock) begin
        if (reset) begin
            speed   <= speed_t'(INIT_SPEED);
            period  <= period_of(speed_t'(INIT_SPEED));
            changed <= 1'b0;
        end else begin
            speed   <= speed_next;
            period  <= period_of(speed_next);
            changed <= changed_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_speed_select.sv
`default_nettype none
// ============================================================================
//  Module   : tb_speed_select
//  Desc     : Scoreboard bench for speed_select with DEBOUNCE_CYCLES = 4.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_speed_select;

    localparam int D = 4;

    typedef struct {
        int          cyc;
        logic [1:0]  spd;
        logic [31:0] per;
    } exp_t;

    logic        clock;
    logic        reset;
    logic        key_up_n;
    logic        key_down_n;
    logic [1:0]  speed;
    logic [31:0] period;
    logic        changed;

    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    int   model_speed = 1;
    exp_t sb[$];

    speed_select #(
        .DEBOUNCE_CYCLES(D),
        .PERIOD_0       (32'd1),
        .PERIOD_1       (32'd50_000_000),
        .PERIOD_2       (32'd100_000_000),
        .PERIOD_3       (32'd200_000_000),
        .INIT_SPEED     (1)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .key_up_n   (key_up_n),
        .key_down_n (key_down_n),
        .speed      (speed),
        .period     (period),
        .changed    (changed)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc = cyc + 1;

    function automatic logic [31:0] exp_period(input int s);
        case (s)
            0:       exp_period = 32'd1;
            1:       exp_period = 32'd50_000_000;
            2:       exp_period = 32'd100_000_000;
            default: exp_period = 32'd200_000_000;
        endcase
    endfunction

    // Scoreboard: every changed pulse must match the oldest expected update
    always @(posedge clock) begin
        exp_t e;
        #1;
        if (changed !== 1'b0) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_changed: cycle %0d speed %0d period %0d, no update expected",
                         cyc, speed, period);
            end else begin
                e = sb.pop_front();
                if (cyc !== e.cyc || speed !== e.spd || period !== e.per) begin
                    miscompares++;
                    $display("FAIL changed_event: got cycle %0d speed %0d period %0d, expected cycle %0d speed %0d period %0d",
                             cyc, speed, period, e.cyc, e.spd, e.per);
                end
            end
        end
    end

    // Called at a negedge: record the update expected from a key going low now
    task automatic expect_press(input bit up);
        exp_t e;
        int   ns;
        ns = model_speed;
        if (up && model_speed > 0)       ns = model_speed - 1;
        else if (!up && model_speed < 3) ns = model_speed + 1;
        if (ns != model_speed) begin
            model_speed = ns;
            e.cyc = cyc + D + 3;
            e.spd = 2'(ns);
            e.per = exp_period(ns);
            sb.push_back(e);
        end
    endtask

    task automatic press_key(input bit up, input int hold);
        @(negedge clock);
        if (up) key_up_n = 1'b0;
        else    key_down_n = 1'b0;
        expect_press(up);
        repeat (hold) @(negedge clock);
        key_up_n   = 1'b1;
        key_down_n = 1'b1;
        repeat (D + 6) @(negedge clock);
    endtask

    task automatic reset_dut();
        @(negedge clock);
        key_up_n   = 1'b1;
        key_down_n = 1'b1;
        reset      = 1'b1;
        repeat (3) @(negedge clock);
        reset       = 1'b0;
        model_speed = 1;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        key_up_n   = 1'b0;
        key_down_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            vectors++;
            if (speed !== 2'd1 || period !== 32'd50_000_000 || changed !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_state[%0d]: speed %0d period %0d changed %b, expected 1 50000000 0",
                         i, speed, period, changed);
            end
        end
        key_up_n   = 1'b1;
        key_down_n = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        model_speed = 1;
        repeat (D + 6) @(negedge clock);
    endtask

    task automatic test_steady(input string name);
        vectors++;
        if (speed !== 2'(model_speed) || period !== exp_period(model_speed)) begin
            miscompares++;
            $display("FAIL %s: speed %0d period %0d, expected speed %0d period %0d",
                     name, speed, period, model_speed, exp_period(model_speed));
        end
        vectors++;
        if (sb.size() !== 0) begin
            miscompares++;
            $display("FAIL %s_pending: %0d expected updates never seen, expected 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_clean_press();
        press_key(1'b0, 10);
        test_steady("clean_press");
    endtask

    task automatic test_glitch();
        @(negedge clock);
        key_up_n = 1'b0;
        repeat (3) @(negedge clock);
        key_up_n = 1'b1;
        repeat (D + 8) @(negedge clock);
        test_steady("glitch");
    endtask

    task automatic test_saturation();
        reset_dut();
        for (int i = 0; i < 4; i++) press_key(1'b1, 10);
        test_steady("saturate_low");
        for (int i = 0; i < 4; i++) press_key(1'b0, 10);
        test_steady("saturate_high");
    endtask

    task automatic test_simultaneous();
        press_key(1'b1, 10);
        @(negedge clock);
        key_up_n   = 1'b0;
        key_down_n = 1'b0;
        repeat (10) @(negedge clock);
        key_up_n   = 1'b1;
        key_down_n = 1'b1;
        repeat (D + 6) @(negedge clock);
        test_steady("simultaneous");
        key_up_n = 1'b0;
        expect_press(1'b1);
        @(negedge clock);
        key_down_n = 1'b0;
        expect_press(1'b0);
        repeat (10) @(negedge clock);
        key_up_n   = 1'b1;
        key_down_n = 1'b1;
        repeat (D + 6) @(negedge clock);
        test_steady("staggered");
    endtask

    task automatic test_reset_mid();
        reset_dut();
        @(negedge clock);
        key_down_n = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        model_speed = 1;
        expect_press(1'b0);
        repeat (D + 8) @(negedge clock);
        key_down_n = 1'b1;
        repeat (D + 6) @(negedge clock);
        test_steady("reset_mid");
    endtask

    initial begin
        test_reset();
        test_steady("post_reset");
        test_clean_press();
        test_glitch();
        test_saturation();
        test_simultaneous();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
